pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Output-side companion to the push-button conditioner. It turns single-cycle event pulses (move accepted, invalid move, player switch) into human-visible LED blinks of fixed on-time, separated by a guaranteed off-time. Events that arrive while a blink is in progress are queued in a saturating counter, so each event produces its own distinct blink. It sits between game-control logic and the board LED pins.

## Interface
- HOLD_CYCLES, 25_000_000, LED on-time per blink in clk cycles; must be ≥1
- GAP_CYCLES, 12_500_000, forced LED off-time after each blink in clk cycles; must be ≥1
- PEND_W, 4, width of the pending-event counter; maximum queue depth is 2^PEND_W−1
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- pulse_in  input  1  event strobe, one cycle per event; sampled every rising edge
- led_out  output  1  stretched blink, registered
- busy  output  1  high while state ≠ IDLE, registered
- pending  output  PEND_W  queued events not yet started
- overflow  output  1  one-cycle pulse when an event is dropped because the queue is saturated

## Operation
- Reset values: state IDLE, led_out 0, busy 0, pending 0, overflow 0, and down-counter 0. pulse_in is ignored while reset is high.
- Down-counter width: $clog2(max(HOLD_CYCLES, GAP_CYCLES)), minimum 1.
- IDLE: led_out is 0. On pulse_in, go to HOLD and load the counter with HOLD_CYCLES−1.
- HOLD: led_out is 1.
  - At counter 0, go to GAP and load GAP_CYCLES−1.
  - Otherwise decrement.
- GAP: led_out is 0. At counter 0:
  - If pending>0 or pulse_in is high this cycle, go to HOLD.
  - Else go to IDLE.
- Pending accounting, applied in HOLD and GAP:
  - pulse_in increments pending.
  - A GAP→HOLD transition driven by the queue decrements pending.
  - If both happen in the same cycle, pending is unchanged.
  - If pulse_in arrives on the last GAP cycle with pending=0, the transition goes directly to HOLD and pending stays 0.
- Saturation: if pulse_in arrives while pending = 2^PEND_W−1 and no decrement occurs that cycle, the event is dropped, pending holds, and overflow is high for exactly the next cycle.
- Reset mid-operation: on the cycle after reset, all outputs return to reset values. Queued events are discarded and no partial blink resumes.

## Timing
- All outputs are registered. For a pulse_in sampled at edge t with the block in IDLE:
  - led_out is high for cycles t+1 … t+HOLD_CYCLES.
  - led_out is low for t+HOLD_CYCLES+1 … t+HOLD_CYCLES+GAP_CYCLES.
- The next queued blink starts at t+HOLD_CYCLES+GAP_CYCLES+1. Blink period under backlog is exactly HOLD_CYCLES+GAP_CYCLES.
- busy rises with led_out and falls on the cycle state returns to IDLE. busy stays high across back-to-back blinks.
- pending updates one cycle after the sampling edge.
- Throughput: one blink per HOLD_CYCLES+GAP_CYCLES cycles. Burst absorption is 2^PEND_W−1 events beyond the active blink.

## Configuration
- PULSE_STRETCH_RETRIGGER_EN
  - Defined: pulse_in during HOLD reloads the counter with HOLD_CYCLES−1 and does not touch pending, so the blink is extended. pulse_in during GAP still queues as described above, and overflow can only occur in GAP.
  - Undefined: pulse_in during HOLD queues into pending, as described in Operation.

## Test plan
Parameters: HOLD_CYCLES=4, GAP_CYCLES=2, PEND_W=2. Macro undefined unless stated.
- Single pulse at cycle 10 → led_out high 11–14, low 15–16; busy high 11–16; IDLE at 17; pending 0 throughout.
- Pulses at 10, 12, 13 → pending 1 at 13, 2 at 14; blinks 11–14, 17–20, 23–26; pending 1 at 17, 0 at 23.
- Pulses at 10, 11, 12, 13, 14 → pending saturates at 3 by cycle 14; pulse 14 dropped; overflow high only at 15; exactly four blinks total.
- Pulse at 10, then pulse at 16 (last GAP cycle) with pending 0 → second blink 17–20; pending remains 0.
- Pulses at 10, 11, 12, with reset high at cycle 13 → at 14: led_out 0, busy 0, pending 0; no further blinks; pulse_in at 13 ignored.
- Macro defined; pulses at 10 and 13 → led_out high 11–17, low 18–19, IDLE at 20; pending 0.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-length LED blinks separated by a forced gap.
// Optional macro PULSE_STRETCH_RETRIGGER_EN: a pulse during a blink extends it instead of queueing.
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [PEND_W-1:0] pend_d;
  logic              ovf_d;
  logic              cnt_zero;
  logic              gap_end;
  logic              queue_start;
  logic              enqueue;

  assign cnt_zero    = (cnt == '0);
  assign gap_end     = (state == GAP) && cnt_zero;
  assign queue_start = gap_end && (pending != '0);

  // A pulse on the final gap cycle with an empty queue starts the next blink directly.
`ifdef PULSE_STRETCH_RETRIGGER_EN
  assign enqueue = pulse_in && (state == GAP) && !(gap_end && (pending == '0));
`else
  assign enqueue = pulse_in && (state != IDLE) && !(gap_end && (pending == '0));
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (pulse_in) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (pulse_in) begin
          cnt_d = HOLD_LOAD;
        end else
`endif
        if (cnt_zero) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt_zero) begin
          if ((pending != '0) || pulse_in) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pend_d = pending;
    ovf_d  = 1'b0;
    if (queue_start && !enqueue) begin
      pend_d = pending - PEND_W'(1);
    end else if (enqueue && !queue_start) begin
      if (pending == '1) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pending + PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      led_out  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      pending  <= pend_d;
      overflow <= ovf_d;
      led_out  <= (state_d == HOLD);
      busy     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomized plus scenario-driven bench for pulse_stretcher against a timeline-based reference model.
module tb_pulse_stretcher;

  localparam int H     = 4;
  localparam int G     = 2;
  localparam int PW    = 2;
  localparam int QMAX  = (1 << PW) - 1;

  logic          clk;
  logic          reset;
  logic          pulse_in;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int errs;
  int checks;
  int cyc;

  // Reference: a blink is described by the edge t0 that accepted it; everything else is offset arithmetic.
  bit m_act;
  int m_t0;
  int m_q;
  bit m_ovf;

  pulse_stretcher #(
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G),
    .PEND_W     (PW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pulse_in(pulse_in),
    .led_out (led_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input bit p, input bit r);
    int e;
    m_ovf = 1'b0;
    if (r) begin
      m_act = 1'b0;
      m_q   = 0;
    end else if (!m_act) begin
      if (p) begin
        m_act = 1'b1;
        m_t0  = cyc;
      end
    end else begin
      e = cyc - m_t0;
      if (e == H + G) begin
        if (m_q > 0) begin
          m_t0 = cyc;
          if (!p) m_q--;
        end else if (p) begin
          m_t0 = cyc;
        end else begin
          m_act = 1'b0;
        end
      end
`ifdef PULSE_STRETCH_RETRIGGER_EN
      else if (p && e <= H) begin
        m_t0 = cyc;
      end
`endif
      else if (p) begin
        if (m_q == QMAX) m_ovf = 1'b1;
        else m_q++;
      end
    end
  endtask

  task automatic step(input bit p, input bit r);
    int off;
    @(negedge clk);
    pulse_in = p;
    reset    = r;
    @(posedge clk);
    model_edge(p, r);
    #1;
    off = cyc + 1 - m_t0;
    check("led_out",  int'(led_out),  (m_act && off >= 1 && off <= H) ? 1 : 0);
    check("busy",     int'(busy),     m_act ? 1 : 0);
    check("pending",  int'(pending),  m_q);
    check("overflow", int'(overflow), m_ovf ? 1 : 0);
    cyc++;
  endtask

  typedef struct {
    logic [15:0] p;
    logic [15:0] r;
  } scen_t;

  scen_t scen [6];

  initial begin
    errs     = 0;
    checks   = 0;
    cyc      = 0;
    m_act    = 1'b0;
    m_t0     = 0;
    m_q      = 0;
    m_ovf    = 1'b0;
    pulse_in = 1'b0;
    reset    = 1'b1;

    scen[0] = '{p: 16'h0001, r: 16'h0000};
    scen[1] = '{p: 16'h000D, r: 16'h0000};
    scen[2] = '{p: 16'h001F, r: 16'h0000};
    scen[3] = '{p: 16'h0041, r: 16'h0000};
    scen[4] = '{p: 16'h000F, r: 16'h0008};
    scen[5] = '{p: 16'h0009, r: 16'h0000};

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

    foreach (scen[s]) begin
      for (int unsigned k = 0; k < 16; k++) begin
        step(scen[s].p[k], scen[s].r[k]);
      end
      for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
    end

    // Random phases sweep from sparse events to saturating bursts.
    for (int ph = 0; ph < 6; ph++) begin
      int prob;
      prob = 5 + ph * 18;
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, 99) < prob, $urandom_range(0, 199) == 0);
      end
      for (int i = 0; i < 60; i++) step(1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
